// File: rtl/bp_pkg.sv
// Shared types for the branch target predictor: counter encoding, BTB entry layout, counter update.
package bp_pkg;

  localparam int TAG_MAX = 30;

  typedef enum logic [1:0] {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T} bp_ctr_t;

  // Tag field is sized for the smallest legal table; unused high bits stay zero.
  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
    bp_ctr_t            ctr;
  } btb_entry_t;

  function automatic bp_ctr_t ctr_next(bp_ctr_t c, logic taken);
    logic [1:0] v;
    v = c;
    if (taken) v = (c == STRONG_T)  ? v : v + 2'd1;
    else       v = (c == STRONG_NT) ? v : v - 2'd1;
    return bp_ctr_t'(v);
  endfunction

endpackage

// File: rtl/bp_btb_table.sv
// Direct-mapped BTB storage: one async lookup port and one sync training port that does its own read-modify-write.
module bp_btb_table
  import bp_pkg::*;
#(
  parameter int         ENTRIES      = 64,
  parameter int         IDX_W        = $clog2(ENTRIES),
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDX_W-1:0]   rd_idx,
  output btb_entry_t         rd_entry,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_MAX-1:0] wr_tag,
  input  logic               wr_taken,
  input  logic [31:0]        wr_target
);

  btb_entry_t mem [ENTRIES];
  btb_entry_t cur;
  logic       wr_hit;

  assign rd_entry = mem[rd_idx];
  assign cur      = mem[wr_idx];
  assign wr_hit   = cur.valid && (cur.tag == wr_tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: bp_ctr_t'(COUNTER_INIT)};
    end else if (wr_en) begin
      if (wr_hit) begin
        mem[wr_idx].ctr <= ctr_next(cur.ctr, wr_taken);
        if (wr_taken) mem[wr_idx].target <= wr_target;
      end else if (wr_taken) begin
        // Taken miss evicts whatever aliased into this slot.
        mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: WEAK_T};
      end
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-stage BTB predictor: same-cycle lookup, IF->ID shadow of the prediction, ID-stage check/train, perf counters.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int         ENTRIES      = 64,
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  output logic        prediction,
  output logic [31:0] pc_predict,
  input  logic        id_is_branch,
  input  logic        id_branch_taken,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_target,
  output logic        mispredict,
  output logic [31:0] lookups,
  output logic [31:0] hits,
  output logic [31:0] updates,
  output logic [31:0] mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]   if_idx, id_idx;
  logic [TAG_MAX-1:0] if_tag, id_tag;
  btb_entry_t         rd;
  logic               hit, resolve, train;
  logic               sh_valid, sh_pred;
  logic [31:0]        sh_target;
  logic               unused_pc_lsbs;

  assign if_idx = if_pc[IDX_W+1:2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign if_tag = TAG_MAX'(if_pc[31:IDX_W+2]);
  assign id_tag = TAG_MAX'(id_pc[31:IDX_W+2]);
  assign unused_pc_lsbs = ^{if_pc[1:0], id_pc[1:0]};

  bp_btb_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .COUNTER_INIT(COUNTER_INIT)) u_table (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (if_idx),
    .rd_entry  (rd),
    .wr_en     (train),
    .wr_idx    (id_idx),
    .wr_tag    (id_tag),
    .wr_taken  (id_branch_taken),
    .wr_target (id_target)
  );

  assign hit        = rd.valid && (rd.tag == if_tag);
  assign prediction = hit && rd.ctr[1];
  assign pc_predict = prediction ? rd.target : if_pc + 32'd4;

  assign resolve    = id_is_branch && sh_valid;
  assign mispredict = resolve && ((sh_pred != id_branch_taken) ||
                                  (id_branch_taken && (sh_target != id_target)));
  // Stall holds the branch in ID, so training waits for the release edge.
  assign train      = resolve && !stall && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_valid  <= 1'b0;
      sh_pred   <= 1'b0;
      sh_target <= '0;
    end else if (flush) begin
      sh_valid  <= 1'b0;
    end else if (!stall) begin
      sh_valid  <= 1'b1;
      sh_pred   <= prediction;
      sh_target <= pc_predict;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookups     <= '0;
      hits        <= '0;
      updates     <= '0;
      mispredicts <= '0;
    end else begin
      if (!stall)          lookups     <= lookups + 32'd1;
      if (!stall && hit)   hits        <= hits + 32'd1;
      if (train)           updates     <= updates + 32'd1;
      if (train && mispredict) mispredicts <= mispredicts + 32'd1;
    end
  end

endmodule
